// File: rtl/lab3_demux4_capture_if.sv
// rtl/lab3_demux4_capture_if.sv - serial capture bus between bit source and demux/capture block
interface lab3_demux4_capture_if;
  logic       din;
  logic       din_valid;
  logic       ctrl;
  logic [1:0] s;
  logic [3:0] q;
  logic       q_valid;
  logic [1:0] slot;
  logic       busy;
  logic       timeout;

  modport master (
    output din, din_valid, ctrl, s,
    input  q, q_valid, slot, busy, timeout
  );

  modport slave (
    input  din, din_valid, ctrl, s,
    output q, q_valid, slot, busy, timeout
  );
endinterface

// File: rtl/lab3_demux4_capture.sv
// rtl/lab3_demux4_capture.sv - 4-slot serial demultiplexer with auto-scan frame capture and direct write
module lab3_demux4_capture #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input logic                  clk,
  input logic                  reset,
  lab3_demux4_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Idle count at which the next empty COLLECT cycle abandons the frame.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [1:0]    slot_cnt, slot_next;
  logic [3:0]    shadow, shadow_next;
  logic [3:0]    q_hold, q_next;
  logic          valid_pulse, valid_next;
  logic          timeout_pulse, timeout_next;
  logic [CW-1:0] idle_cnt, cnt_next;

  // State and datapath registers; reset overrides everything, including a frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      slot_cnt      <= 2'd0;
      shadow        <= 4'b0000;
      q_hold        <= 4'b0000;
      valid_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      state         <= state_next;
      slot_cnt      <= slot_next;
      shadow        <= shadow_next;
      q_hold        <= q_next;
      valid_pulse   <= valid_next;
      timeout_pulse <= timeout_next;
      idle_cnt      <= cnt_next;
    end
  end

  // Next-state and next-value logic; mode is only looked at in IDLE so a frame always finishes in the mode it started.
  always_comb begin
    state_next   = state;
    slot_next    = slot_cnt;
    shadow_next  = shadow;
    q_next       = q_hold;
    valid_next   = 1'b0;
    timeout_next = 1'b0;
    cnt_next     = idle_cnt;

    case (state)
      IDLE: begin
        if (bus.din_valid) begin
          if (bus.ctrl) begin
            q_next[bus.s] = bus.din;
            valid_next    = 1'b1;
          end else begin
            shadow_next[0] = bus.din;
            slot_next      = 2'd1;
            cnt_next       = '0;
            state_next     = COLLECT;
          end
        end
      end

      COLLECT: begin
        // An arriving bit beats the timeout even on the cycle the limit would be hit.
        if (bus.din_valid) begin
          shadow_next[slot_cnt] = bus.din;
          cnt_next              = '0;
          if (slot_cnt == 2'd3) begin
            // Slot holds at 3 here; it returns to 0 only when DONE publishes the frame.
            state_next = DONE;
          end else begin
            slot_next = slot_cnt + 2'd1;
          end
        end else if (idle_cnt == TO_LAST) begin
          timeout_next = 1'b1;
          shadow_next  = 4'b0000;
          slot_next    = 2'd0;
          cnt_next     = '0;
          state_next   = IDLE;
        end else begin
          cnt_next = idle_cnt + CW'(1);
        end
      end

      DONE: begin
        // Any bit offered here is dropped; the next frame must start from IDLE.
        q_next     = shadow;
        valid_next = 1'b1;
        slot_next  = 2'd0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.q       = q_hold;
  assign bus.q_valid = valid_pulse;
  assign bus.slot    = slot_cnt;
  assign bus.busy    = (state != IDLE);
  assign bus.timeout = timeout_pulse;

endmodule

// File: tb/tb_lab3_demux4_capture.sv
// tb/tb_lab3_demux4_capture.sv - directed self-checking bench for lab3_demux4_capture
module tb_lab3_demux4_capture;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   timeout_seen;

  lab3_demux4_capture_if bus ();

  lab3_demux4_capture #(.TIMEOUT_CYCLES(200)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sticky count of timeout pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.timeout === 1'b1) timeout_seen = timeout_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic b);
    bus.din       = b;
    bus.din_valid = 1'b1;
    step(1);
    bus.din_valid = 1'b0;
  endtask

  task automatic outs(input string tag, input logic [3:0] eq, input logic ev,
                      input logic [1:0] es, input logic eb, input logic et);
    check({tag, ".q"},       32'(bus.q),       32'(eq));
    check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(ev));
    check({tag, ".slot"},    32'(bus.slot),    32'(es));
    check({tag, ".busy"},    32'(bus.busy),    32'(eb));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(et));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    timeout_seen  = 0;
    reset         = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.ctrl      = 1'b0;
    bus.s         = 2'd0;
    step(2);
    outs("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Auto frame 1,0,1,1 starting in the very first cycle out of reset.
    reset = 1'b0;
    send(1'b1);
    outs("auto.b1", 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0);
    send(1'b0);
    check("auto.b2.slot", 32'(bus.slot), 32'd2);
    send(1'b1);
    outs("auto.b3", 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    step(1);
    outs("auto.b4", 4'b0000, 1'b0, 2'd3, 1'b1, 1'b0);
    bus.din = 1'b0;
    step(1);
    outs("auto.done", 4'b1101, 1'b1, 2'd0, 1'b0, 1'b0);
    bus.din_valid = 1'b0;
    step(1);
    outs("auto.hold", 4'b1101, 1'b0, 2'd0, 1'b0, 1'b0);

    // Gapped frame 0,1,1,0 with 10 idle cycles between bits.
    timeout_seen = 0;
    send(1'b0); step(10);
    send(1'b1); step(10);
    send(1'b1); step(10);
    check("gap.midframe.q", 32'(bus.q), 32'b1101);
    send(1'b0);
    step(1);
    outs("gap.done", 4'b0110, 1'b1, 2'd0, 1'b0, 1'b0);
    check("gap.no_timeout", 32'(timeout_seen), 32'd0);

    // Restore q = 1101, then abandon a 2-bit frame through the timeout.
    send(1'b1); send(1'b0); send(1'b1); send(1'b1);
    step(1);
    check("to.pre.q", 32'(bus.q), 32'b1101);
    send(1'b0); send(1'b0);
    step(199);
    outs("to.edge199", 4'b1101, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1);
    outs("to.fire", 4'b1101, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1);
    outs("to.after", 4'b1101, 1'b0, 2'd0, 1'b0, 1'b0);

    // Bit arriving on the exact cycle the limit would be hit must win; frame 0,1,0,0.
    timeout_seen = 0;
    send(1'b0);
    step(199);
    send(1'b1);
    outs("race.bit", 4'b1101, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b0); send(1'b0);
    step(1);
    outs("race.done", 4'b0010, 1'b1, 2'd0, 1'b0, 1'b0);
    check("race.no_timeout", 32'(timeout_seen), 32'd0);

    // Reset after the third bit of an auto frame, din_valid still high.
    send(1'b1); send(1'b1); send(1'b1);
    reset         = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b1;
    step(1);
    outs("rst.mid", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    send(1'b1); send(1'b1); send(1'b1); send(1'b0);
    step(1);
    outs("rst.next", 4'b0111, 1'b1, 2'd0, 1'b0, 1'b0);

    // Direct-address sweep from a cleared q.
    reset = 1'b1;
    step(1);
    reset    = 1'b0;
    bus.ctrl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.s = 2'(i);
      send(1'b1);
      outs($sformatf("dir.s%0d", i), 4'((1 << (i + 1)) - 1), 1'b1, 2'd0, 1'b0, 1'b0);
    end
    step(1);
    outs("dir.hold", 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0);

    // ctrl flipped to direct after the first auto bit: frame stays auto, s ignored.
    bus.ctrl = 1'b0;
    send(1'b0);
    bus.ctrl = 1'b1;
    bus.s    = 2'd3;
    send(1'b1);
    outs("mode.b2", 4'b1111, 1'b0, 2'd2, 1'b1, 1'b0);
    send(1'b0); send(1'b0);
    step(1);
    outs("mode.done", 4'b0010, 1'b1, 2'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lab3_demux4_capture.md
LAB3_DEMUX4_CAPTURE -- requirements
Module: lab3_demux4_capture

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 200, number of idle cycles tolerated inside a frame before it is abandoned.
REQ-002 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: din  input  1  serial data bit.
REQ-005 Port: din_valid  input  1  din qualifier, one bit accepted per cycle high.
REQ-006 Port: ctrl  input  1  mode: 0 = auto-scan frame capture, 1 = direct-address write.
REQ-007 Port: s  input  2  slot address, used only in direct mode.
REQ-008 Port: q  output  4  held demultiplexed outputs, q[i] = slot i.
REQ-009 Port: q_valid  output  1  one-cycle pulse when q is updated.
REQ-010 Port: slot  output  2  next auto-scan slot to be written.
REQ-011 Port: busy  output  1  high while a frame is in progress (state COLLECT or DONE).
REQ-012 Port: timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, COLLECT, DONE; one-hot or binary encoding at implementer's choice.
REQ-014 ctrl SHALL be sampled only in IDLE; ctrl changes during COLLECT/DONE SHALL be ignored until return to IDLE.
REQ-015 Auto mode, IDLE + din_valid: write din to shadow[0], slot <= 1, state <= COLLECT.
REQ-016 Auto mode, COLLECT + din_valid: write din to shadow[slot], slot <= slot+1; if slot was 3, state <= DONE.
REQ-017 DONE: q <= shadow (all 4 bits in one cycle), q_valid = 1 for exactly that cycle, slot <= 0, state <= IDLE.
REQ-018 Latency: q and q_valid SHALL update on the clock edge one cycle after the edge accepting the 4th bit.
REQ-019 q SHALL hold its value between updates; shadow writes SHALL NOT be visible on q before DONE.
REQ-020 Direct mode, IDLE + din_valid: q[s] <= din on the next edge, other q bits unchanged, q_valid pulses 1 cycle, state stays IDLE, slot stays 0.
REQ-021 Timeout counter SHALL clear on entry to COLLECT and on every accepted bit, and increment each COLLECT cycle without din_valid.
REQ-022 When the counter reaches TIMEOUT_CYCLES: timeout = 1 for one cycle, shadow discarded, slot <= 0, state <= IDLE, q unchanged, q_valid = 0.
REQ-023 din_valid in the same cycle the counter would reach TIMEOUT_CYCLES SHALL win: bit accepted, counter cleared, no timeout.
REQ-024 din_valid during DONE SHALL be ignored (bit dropped); the next frame starts only from IDLE.
REQ-025 slot SHALL wrap 3 -> 0 only via DONE; no other wrap path exists.
REQ-026 busy SHALL be 1 in COLLECT and DONE, 0 in IDLE.

Reset
REQ-027 reset SHALL take effect on the rising clk edge while high, overriding all other inputs, including mid-frame.
REQ-028 Reset values: state IDLE, q = 4'b0000, shadow = 0, slot = 0, q_valid = 0, busy = 0, timeout = 0, counter = 0.
REQ-029 The first din_valid honoured after reset deassertion SHALL be in the first cycle reset is low.

Verification
REQ-030 Auto frame: ctrl=0, din_valid high 4 consecutive cycles with din 1,0,1,1 -> one cycle later q = 4'b1101, q_valid single pulse, slot back to 0.
REQ-031 Gapped frame: ctrl=0, bits 0,1,1,0 with 10 idle cycles between each (TIMEOUT_CYCLES=200) -> q = 4'b0110, no timeout.
REQ-032 Timeout: ctrl=0, q previously 4'b1101, send 2 bits then 200 idle cycles -> timeout pulse, q stays 4'b1101, busy 0, slot 0; next full frame captures correctly.
REQ-033 Direct mode: ctrl=1, sweep s = 00,01,10,11 with din=1 -> q steps 0001, 0011, 0111, 1111, q_valid pulse per write, busy stays 0.
REQ-034 ctrl toggled to 1 after first bit of auto frame -> frame completes in auto mode; s ignored.
REQ-035 Reset asserted after 3rd bit of auto frame -> all outputs at reset values next edge; subsequent 4-bit frame yields correct q.
